// File: rtl/opora_load_ctrl.sv
// Opora frame loader: parses MAGIC + coefficients + checksum from the
// Ethernet side and writes a shadow bank, committing it only on a good sum.
//
// Ports:
//   clke, rst_n               clock, synchronous active-low reset
//   opora_en/opora_sof/OPORA  incoming word strobe, frame start, word
//   KOEF_OUT/koef_en/koef_addr coefficient write to block koef_en at addr
//   koef_bank/active_bank     shadow bank written / bank in use
//   opora_ready               one-cycle pulse on commit
//   load_busy                 frame in progress (LOAD or CHK)
//   err_pulse/err_code        error strobe and held code
//                             (0 sum, 1 header, 2 abort, 3 timeout)
//   good_cnt/bad_cnt          saturating frame/error counters
module opora_load_ctrl #(
    parameter int          N       = 4,
    parameter int          MULT_N  = 25,
    parameter int          NLOG    = $clog2(MULT_N),
    parameter logic [15:0] MAGIC   = 16'hA55A,
    parameter int          TIMEOUT = 1023
) (
    input  logic            clke,
    input  logic            rst_n,
    input  logic            opora_en,
    input  logic            opora_sof,
    input  logic [15:0]     OPORA,
    output logic [15:0]     KOEF_OUT,
    output logic [N-1:0]    koef_en,
    output logic [NLOG-1:0] koef_addr,
    output logic            koef_bank,
    output logic            active_bank,
    output logic            opora_ready,
    output logic            load_busy,
    output logic            err_pulse,
    output logic [1:0]      err_code,
    output logic [7:0]      good_cnt,
    output logic [7:0]      bad_cnt
);

    localparam int BLKW = (N > 1) ? $clog2(N) : 1;
    localparam int GAPW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHK,
        S_COMMIT
    } state_t;

    state_t            r_state;
    logic [BLKW-1:0]   r_blk;
    logic [NLOG-1:0]   r_addr;
    logic [15:0]       r_sum;
    logic [GAPW-1:0]   r_gap;

    state_t            w_next;
    logic              w_wr;
    logic              w_clr;
    logic              w_err;
    logic [1:0]        w_code;
    logic              w_commit;
    logic              w_magic;
    logic              w_last;
    logic              w_tout;
    logic              w_addr_wrap;

    assign w_magic     = (OPORA == MAGIC);
    assign w_addr_wrap = (r_addr == NLOG'(MULT_N - 1));
    assign w_last      = w_addr_wrap && (r_blk == BLKW'(N - 1));
    assign w_tout      = (r_gap == GAPW'(TIMEOUT));

    always_comb begin
        w_next   = r_state;
        w_wr     = 1'b0;
        w_clr    = 1'b0;
        w_err    = 1'b0;
        w_code   = 2'd0;
        w_commit = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (opora_en && opora_sof) begin
                    if (w_magic) begin
                        w_next = S_LOAD;
                        w_clr  = 1'b1;
                    end else begin
                        w_err  = 1'b1;
                        w_code = 2'd1;
                    end
                end
            end
            S_LOAD, S_CHK: begin
                if (w_tout) begin
                    w_err  = 1'b1;
                    w_code = 2'd3;
                    w_next = S_IDLE;
                end else if (opora_en && opora_sof) begin
                    // A new SOF aborts the current frame; a valid
                    // header restarts loading immediately.
                    w_err  = 1'b1;
                    w_code = 2'd2;
                    if (w_magic) begin
                        w_next = S_LOAD;
                        w_clr  = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end else if (opora_en) begin
                    if (r_state == S_LOAD) begin
                        w_wr = 1'b1;
                        if (w_last) w_next = S_CHK;
                    end else if (OPORA == r_sum) begin
                        w_next = S_COMMIT;
                    end else begin
                        w_err  = 1'b1;
                        w_code = 2'd0;
                        w_next = S_IDLE;
                    end
                end
            end
            S_COMMIT: begin
                w_commit = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clke) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_blk       <= '0;
            r_addr      <= '0;
            r_sum       <= '0;
            r_gap       <= '0;
            KOEF_OUT    <= '0;
            koef_en     <= '0;
            koef_addr   <= '0;
            koef_bank   <= 1'b1;
            active_bank <= 1'b0;
            opora_ready <= 1'b0;
            load_busy   <= 1'b0;
            err_pulse   <= 1'b0;
            err_code    <= 2'd0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
        end else begin
            r_state <= w_next;

            // Cascaded block/address counters instead of a divider.
            if (w_clr) begin
                r_blk  <= '0;
                r_addr <= '0;
                r_sum  <= '0;
            end else if (w_wr) begin
                r_sum <= r_sum + OPORA;
                if (w_addr_wrap) begin
                    r_addr <= '0;
                    r_blk  <= r_blk + BLKW'(1);
                end else begin
                    r_addr <= r_addr + NLOG'(1);
                end
            end

            // Idle-gap counter saturates at TIMEOUT.
            if (opora_en || r_state == S_IDLE ||
                r_state == S_COMMIT) begin
                r_gap <= '0;
            end else if (!w_tout) begin
                r_gap <= r_gap + GAPW'(1);
            end

            koef_en <= w_wr ? (N'(1) << r_blk) : '0;
            if (w_wr) begin
                KOEF_OUT  <= OPORA;
                koef_addr <= r_addr;
            end

            active_bank <= active_bank ^ w_commit;
            koef_bank   <= ~(active_bank ^ w_commit);
            opora_ready <= w_commit;
            if (w_commit && good_cnt != 8'hFF)
                good_cnt <= good_cnt + 8'd1;

            load_busy <= (w_next == S_LOAD) || (w_next == S_CHK);

            err_pulse <= w_err;
            if (w_err) begin
                err_code <= w_code;
                if (bad_cnt != 8'hFF) bad_cnt <= bad_cnt + 8'd1;
            end
        end
    end

endmodule
